// File: rtl/conv_ctrl.sv
// conv_ctrl: sequences a valid-mode 2-D convolution of an IMGROW x IMGCOL
// image with a KxK signed kernel, one output pixel every K*K+2 cycles.
// Ports: clk/rst (async active-high); start/busy/done handshake; img_rd_en,
//   img_addr/ker_addr read port (data one cycle later on img_data/ker_data);
//   out_we/out_addr/out_data write port.
// Optional feature: define CONV_CTRL_RELU_EN to clamp negatives to zero
//   (ReLU) instead of saturating to the full signed output range.
module conv_ctrl #(
  parameter int IMGROW      = 28,
  parameter int IMGCOL      = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int KDATA_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      img_rd_en,
  output logic [$clog2(IMGROW*IMGCOL)-1:0]          img_addr,
  input  logic [DATA_WIDTH-1:0]                     img_data,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] ker_addr,
  input  logic [KDATA_WIDTH-1:0]                    ker_data,
  output logic                                      out_we,
  output logic [$clog2((IMGROW-KERNEL_SIZE+1)*(IMGCOL-KERNEL_SIZE+1))-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]                     out_data
);

  localparam int K        = KERNEL_SIZE;
  localparam int OUT_ROWS = IMGROW - K + 1;
  localparam int OUT_COLS = IMGCOL - K + 1;
  localparam int IMG_AW   = $clog2(IMGROW*IMGCOL);
  localparam int KER_AW   = $clog2(K*K);
  localparam int OUT_AW   = $clog2(OUT_ROWS*OUT_COLS);
  localparam int ACC_W    = DATA_WIDTH + KDATA_WIDTH + $clog2(K*K) + 1;
  localparam int KW       = $clog2(K+1);
  localparam int RW       = $clog2(OUT_ROWS+1);
  localparam int CW       = $clog2(OUT_COLS+1);

  localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] NEG_MIN = ~POS_MAX;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

  state_t                  state;
  logic [RW-1:0]           orow;
  logic [CW-1:0]           ocol;
  logic [KW-1:0]           kr;
  logic [KW-1:0]           kc;
  logic signed [ACC_W-1:0] acc;
  // Marks the cycle in which the data of last cycle's read is on the bus.
  logic                    rd_pend;

  logic signed [ACC_W-1:0] img_ext;
  logic signed [ACC_W-1:0] ker_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    k_last;
  logic                    col_last;
  logic                    row_last;
  logic [KW-1:0]           nkr;
  logic [KW-1:0]           nkc;
  logic [RW-1:0]           nrow;
  logic [CW-1:0]           ncol;

  always_comb begin
    img_ext  = $signed({{(ACC_W-DATA_WIDTH){1'b0}}, img_data});
    ker_ext  = $signed({{(ACC_W-KDATA_WIDTH){ker_data[KDATA_WIDTH-1]}}, ker_data});
    prod     = img_ext * ker_ext;
    // DRAIN needs the final product folded in before the registered output.
    acc_sum  = rd_pend ? acc + prod : acc;
    k_last   = (kr == KW'(K-1)) && (kc == KW'(K-1));
    nkc      = (kc == KW'(K-1)) ? '0 : kc + KW'(1);
    nkr      = (kc == KW'(K-1)) ? kr + KW'(1) : kr;
    col_last = (ocol == CW'(OUT_COLS-1));
    row_last = (orow == RW'(OUT_ROWS-1));
    ncol     = col_last ? '0 : ocol + CW'(1);
    nrow     = col_last ? orow + RW'(1) : orow;
  end

  function automatic logic [IMG_AW-1:0] img_index(input int r, input int c);
    return IMG_AW'(r*IMGCOL + c);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] activate(input logic signed [ACC_W-1:0] a);
`ifdef CONV_CTRL_RELU_EN
    if (a[ACC_W-1])    return '0;
    else if (a > POS_MAX) return POS_MAX[DATA_WIDTH-1:0];
    else               return a[DATA_WIDTH-1:0];
`else
    if (a > POS_MAX)      return POS_MAX[DATA_WIDTH-1:0];
    else if (a < NEG_MIN) return NEG_MIN[DATA_WIDTH-1:0];
    else                  return a[DATA_WIDTH-1:0];
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      img_rd_en <= 1'b0;
      img_addr  <= '0;
      ker_addr  <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      orow      <= '0;
      ocol      <= '0;
      kr        <= '0;
      kc        <= '0;
      acc       <= '0;
      rd_pend   <= 1'b0;
    end else begin
      rd_pend <= img_rd_en;
      if (rd_pend) acc <= acc_sum;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            orow      <= '0;
            ocol      <= '0;
            kr        <= '0;
            kc        <= '0;
            acc       <= '0;
            img_rd_en <= 1'b1;
            img_addr  <= '0;
            ker_addr  <= '0;
          end
        end
        FETCH: begin
          if (k_last) begin
            state     <= DRAIN;
            img_rd_en <= 1'b0;
            img_addr  <= '0;
            ker_addr  <= '0;
            kr        <= '0;
            kc        <= '0;
          end else begin
            kr       <= nkr;
            kc       <= nkc;
            img_addr <= img_index(int'(orow) + int'(nkr), int'(ocol) + int'(nkc));
            ker_addr <= KER_AW'(int'(nkr)*K + int'(nkc));
          end
        end
        DRAIN: begin
          state    <= WRITE;
          out_we   <= 1'b1;
          out_addr <= OUT_AW'(int'(orow)*OUT_COLS + int'(ocol));
          out_data <= activate(acc_sum);
          acc      <= '0;
        end
        WRITE: begin
          out_we   <= 1'b0;
          out_addr <= '0;
          out_data <= '0;
          if (row_last && col_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            // Next window's first read overlaps nothing: zero-gap streaming.
            state     <= FETCH;
            orow      <= nrow;
            ocol      <= ncol;
            img_rd_en <= 1'b1;
            img_addr  <= img_index(int'(nrow), int'(ncol));
            ker_addr  <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          orow  <= '0;
          ocol  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: randomized and directed bench for conv_ctrl at default size.
// Expected outputs come from a direct convolution model over bench memories.
// Memories answer reads one cycle after img_rd_en, as the controller expects.
module tb_conv_ctrl;
  localparam int IMGROW = 28, IMGCOL = 28, K = 5;
  localparam int ORN = IMGROW - K + 1, OCN = IMGCOL - K + 1;
  localparam int NPIX = IMGROW*IMGCOL, NOUT = ORN*OCN, KK = K*K;
  localparam int PER_OUT = KK + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, img_rd_en, out_we;
  logic [9:0] img_addr;
  logic [4:0] ker_addr;
  logic [9:0] out_addr;
  logic [7:0] out_data;
  logic [7:0] img_data = 8'h00;
  logic [7:0] ker_data = 8'h00;

  conv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_data(img_data),
    .ker_addr(ker_addr), .ker_data(ker_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  logic [7:0] img_mem [NPIX];
  logic [7:0] ker_mem [KK];
  int exp_out [NOUT];

  always @(posedge clk) begin
    if (img_rd_en) begin
      img_data <= img_mem[img_addr];
      ker_data <= ker_mem[ker_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_addr_q[$];
  int wr_data_q[$];
  int rd_img_q[$];
  int rd_ker_q[$];
  int done_cnt = 0;
  int viol = 0;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_we) begin
        wr_addr_q.push_back(int'(out_addr));
        wr_data_q.push_back(int'(out_data));
      end
      if (img_rd_en && rd_img_q.size() < KK) begin
        rd_img_q.push_back(int'(img_addr));
        rd_ker_q.push_back(int'(ker_addr));
      end
      if (done) done_cnt++;
      if (img_rd_en && out_we) viol++;
      if (!img_rd_en && (img_addr != 0 || ker_addr != 0)) viol++;
      if (!out_we && (out_addr != 0 || out_data != 0)) viol++;
    end
  end

  function automatic int act(input int s);
`ifdef CONV_CTRL_RELU_EN
    if (s < 0) return 0;
    if (s > 127) return 127;
    return s;
`else
    if (s > 127) return 127;
    if (s < -128) return 128;
    return s & 255;
`endif
  endfunction

  function automatic void compute_expected();
    for (int r = 0; r < ORN; r++)
      for (int c = 0; c < OCN; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += int'(img_mem[(r+i)*IMGCOL + c + j]) * int'($signed(ker_mem[i*K + j]));
        exp_out[r*OCN + c] = act(s);
      end
  endfunction

  function automatic void fill_const(input logic [7:0] iv, input logic [7:0] kv);
    for (int i = 0; i < NPIX; i++) img_mem[i] = iv;
    for (int i = 0; i < KK; i++) ker_mem[i] = kv;
  endfunction

  // Returns number of logged writes disagreeing with the model (in order).
  function automatic int count_bad(input int n, output int first);
    int bad;
    bad = 0;
    first = -1;
    for (int i = 0; i < n && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != i || wr_data_q[i] != exp_out[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    return bad;
  endfunction

  task automatic clear_logs();
    @(posedge clk);
    wr_addr_q.delete(); wr_data_q.delete();
    rd_img_q.delete(); rd_ker_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(output int s_edge);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 s_edge = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (wr_addr_q.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit to, output int d_edge);
    to = 1'b1;
    d_edge = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; d_edge = cyc; break; end
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, img_rd_en, out_we} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, img_rd_en, out_we});
    end
    checks++;
    if ({img_addr, ker_addr, out_addr, out_data} !== 33'b0) begin
      errors++; $display("FAIL reset_bus got %h want 0", {img_addr, ker_addr, out_addr, out_data});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, img_rd_en, out_we} !== 4'b0) begin
      errors++; $display("FAIL idle_ctrl got %b want 0000", {busy, done, img_rd_en, out_we});
    end
  endtask

  task automatic test_ones();
    int s, d, bad, first;
    bit to;
    fill_const(8'h01, 8'h01);
    compute_expected();
    clear_logs();
    pulse_start(s);
    wait_done(NOUT*PER_OUT + 100, to, d);
    checks++;
    if (to) begin errors++; $display("FAIL ones_done_timeout got none want done"); end
    checks++;
    if (d - s != NOUT*PER_OUT) begin
      errors++; $display("FAIL ones_latency got %0d want %0d", d - s, NOUT*PER_OUT);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ones_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (wr_addr_q.size() != NOUT || done_cnt != 1) begin
      errors++; $display("FAIL ones_counts got writes=%0d dones=%0d want %0d 1", wr_addr_q.size(), done_cnt, NOUT);
    end
    bad = count_bad(NOUT, first);
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ones_data got %0d bad (first %0d) want 0", bad, first);
    end
    checks++;
    if (wr_data_q.size() < 1 || wr_data_q[0] != 8'h19) begin
      errors++; $display("FAIL ones_value got %0d want 25", wr_data_q.size() > 0 ? wr_data_q[0] : -1);
    end
  endtask

  // Partial pass over n outputs of a uniform pattern, then abort with reset.
  task automatic run_partial(input string nm, input logic [7:0] iv, input logic [7:0] kv,
                             input int want);
    int s, bad, first;
    bit to;
    fill_const(iv, kv);
    compute_expected();
    clear_logs();
    pulse_start(s);
    wait_writes(30, 30*PER_OUT + 100, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout got %0d writes want 30", nm, wr_addr_q.size()); end
    bad = count_bad(30, first);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_model got %0d bad (first %0d) want 0", nm, bad, first); end
    checks++;
    if (wr_data_q.size() < 1 || wr_data_q[0] != want) begin
      errors++; $display("FAIL %s_value got %0d want %0d", nm, wr_data_q.size() > 0 ? wr_data_q[0] : -1, want);
    end
    rst_pulse();
  endtask

  task automatic test_negative();
`ifdef CONV_CTRL_RELU_EN
    run_partial("neg", 8'h01, 8'hFF, 8'h00);
`else
    run_partial("neg", 8'h01, 8'hFF, 8'hE7);
`endif
  endtask

  task automatic test_saturation();
    run_partial("sat_pos", 8'hFF, 8'h7F, 8'h7F);
`ifdef CONV_CTRL_RELU_EN
    run_partial("sat_neg", 8'hFF, 8'h80, 8'h00);
`else
    run_partial("sat_neg", 8'hFF, 8'h80, 8'h80);
`endif
  endtask

  task automatic test_ramp();
    int s, bad, first, abad, kbad;
    bit to;
    for (int r = 0; r < IMGROW; r++)
      for (int c = 0; c < IMGCOL; c++) img_mem[r*IMGCOL + c] = 8'(r + c);
    for (int i = 0; i < KK; i++) ker_mem[i] = (i == 0) ? 8'h01 : 8'h00;
    compute_expected();
    clear_logs();
    pulse_start(s);
    wait_writes(60, 60*PER_OUT + 100, to);
    checks++;
    if (to) begin errors++; $display("FAIL ramp_timeout got %0d writes want 60", wr_addr_q.size()); end
    abad = 0; kbad = 0;
    for (int i = 0; i < KK; i++) begin
      if (i >= rd_img_q.size() || rd_img_q[i] != (i/K)*IMGCOL + i%K) abad++;
      if (i >= rd_ker_q.size() || rd_ker_q[i] != i) kbad++;
    end
    checks++;
    if (abad != 0) begin errors++; $display("FAIL ramp_img_addr got %0d bad want 0", abad); end
    checks++;
    if (kbad != 0) begin errors++; $display("FAIL ramp_ker_addr got %0d bad want 0", kbad); end
    bad = count_bad(60, first);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ramp_model got %0d bad (first %0d) want 0", bad, first); end
    checks++;
    if (wr_data_q.size() < 26 || wr_data_q[25] != 2) begin
      errors++; $display("FAIL ramp_out_1_1 got %0d want 2", wr_data_q.size() > 25 ? wr_data_q[25] : -1);
    end
    rst_pulse();
  endtask

  task automatic test_abort_random();
    int s, d, bad, first;
    bit to;
    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < KK; i++) ker_mem[i] = 8'($urandom_range(0, 255));
    compute_expected();
    clear_logs();
    pulse_start(s);
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, img_rd_en, out_we, img_addr, ker_addr, out_addr, out_data} !== 37'b0) begin
      errors++; $display("FAIL abort_outputs got %h want 0",
        {busy, done, img_rd_en, out_we, img_addr, ker_addr, out_addr, out_data});
    end
    @(negedge clk); rst = 1'b0;
    clear_logs();
    repeat (1500) @(posedge clk);
    checks++;
    if (wr_addr_q.size() != 0 || done_cnt != 0) begin
      errors++; $display("FAIL abort_quiet got writes=%0d dones=%0d want 0 0", wr_addr_q.size(), done_cnt);
    end
    clear_logs();
    pulse_start(s);
    wait_done(NOUT*PER_OUT + 100, to, d);
    checks++;
    if (to) begin errors++; $display("FAIL rand_done_timeout got none want done"); end
    @(negedge clk);
    checks++;
    if (wr_addr_q.size() != NOUT || done_cnt != 1) begin
      errors++; $display("FAIL rand_counts got writes=%0d dones=%0d want %0d 1", wr_addr_q.size(), done_cnt, NOUT);
    end
    bad = count_bad(NOUT, first);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_model got %0d bad (first %0d) want 0", bad, first); end
  endtask

  task automatic test_start_held();
    int d;
    bit to;
    clear_logs();
    @(negedge clk); start = 1'b1;
    wait_done(NOUT*PER_OUT + 100, to, d);
    checks++;
    if (to || busy !== 1'b1) begin
      errors++; $display("FAIL held_done got timeout=%0d busy=%b want 0 1", to, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || img_rd_en !== 1'b0) begin
      errors++; $display("FAIL held_idle got busy=%b done=%b rd=%b want 0 0 0", busy, done, img_rd_en);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || img_rd_en !== 1'b1 || img_addr !== 10'd0) begin
      errors++; $display("FAIL held_restart got busy=%b rd=%b addr=%0d want 1 1 0", busy, img_rd_en, img_addr);
    end
    checks++;
    if (done_cnt != 1 || wr_addr_q.size() != NOUT) begin
      errors++; $display("FAIL held_counts got dones=%0d writes=%0d want 1 %0d", done_cnt, wr_addr_q.size(), NOUT);
    end
    start = 1'b0;
    rst_pulse();
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL protocol got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_negative();
    test_saturation();
    test_ramp();
    test_abort_random();
    test_start_held();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter IMGROW, default 28: input image rows.
REQ-002 SHALL have parameter IMGCOL, default 28: input image columns.
REQ-003 SHALL have parameter KERNEL_SIZE, default 5: square kernel edge length K.
REQ-004 SHALL have parameter DATA_WIDTH, default 8: pixel and output width.
REQ-005 SHALL have parameter KDATA_WIDTH, default 8: kernel weight width.
REQ-006 SHALL have ports as follows; one clock; reset is asynchronous and active-high:
- clk  in  1: sole clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: request one full convolution pass.
- busy  out  1: high from the cycle after start is accepted until DONE is exited.
- done  out  1: one-cycle pulse at pass completion.
- img_rd_en  out  1: image memory read strobe.
- img_addr  out  $clog2(IMGROW*IMGCOL): image word address.
- img_data  in  DATA_WIDTH: unsigned pixel, valid exactly one cycle after img_rd_en.
- ker_addr  out  $clog2(K*K): kernel word address, issued with img_rd_en.
- ker_data  in  KDATA_WIDTH: signed two's-complement weight, same one-cycle latency.
- out_we  out  1: output memory write strobe.
- out_addr  out  $clog2(OR*OC): output address, where OR=IMGROW-K+1 and OC=IMGCOL-K+1.
- out_data  out  DATA_WIDTH: activated result.

Function
REQ-007 SHALL implement the states IDLE, FETCH, DRAIN, WRITE and DONE.
REQ-008 In IDLE, start=1 SHALL clear all counters and the accumulator and move to FETCH; start SHALL be ignored in every other state.
REQ-009 FETCH SHALL last K*K cycles and issue one read per cycle with img_rd_en=1:
- iteration order is kr outer, kc inner;
- img_addr=(orow+kr)*IMGCOL+(ocol+kc);
- ker_addr=kr*K+kc.
REQ-010 The accumulator SHALL have width DATA_WIDTH+KDATA_WIDTH+$clog2(K*K)+1, signed. Each cycle after a read it SHALL add zero-extended img_data times sign-extended ker_data.
REQ-011 DRAIN SHALL be one cycle that absorbs the final product; img_rd_en=0.
REQ-012 WRITE SHALL be one cycle:
- out_we=1;
- out_addr=orow*OC+ocol;
- out_data=activate(accumulator) per REQ-020/021;
- the accumulator is cleared.
REQ-013 After WRITE, ocol SHALL increment. At ocol=OC-1 it wraps to 0 and orow increments. If orow=OR-1 and ocol=OC-1, go to DONE; otherwise go to FETCH.
REQ-014 Cost per output SHALL be exactly K*K+2 cycles, with no idle gaps between outputs.
REQ-015 DONE SHALL last one cycle with done=1, busy=1, then return to IDLE.
REQ-016 start asserted in the DONE cycle SHALL be ignored. start asserted in the first IDLE cycle afterwards SHALL be accepted.
REQ-017 img_rd_en and out_we SHALL never be high in the same cycle.
REQ-018 When not strobed, img_addr, ker_addr, out_addr and out_data SHALL hold 0.

Reset
REQ-019 While rst=1, the module SHALL:
- force state=IDLE;
- force busy, done, img_rd_en, out_we=0;
- force all addresses, out_data, counters and the accumulator to 0;
- do this immediately, including mid-pass (the aborted pass produces no further writes and no done).

Configuration
REQ-020 With macro CONV_CTRL_RELU_EN defined: a negative accumulator SHALL output 0. A positive accumulator SHALL saturate to 2^(DATA_WIDTH-1)-1, giving 0x7F at width 8.
REQ-021 Without CONV_CTRL_RELU_EN: the output SHALL be the accumulator saturated to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], two's complement.

Verification (defaults: 28x28 image, K=5, 24x24 output)
REQ-022 Image all 0x01, kernel all 0x01, start pulse. Required:
- 576 writes at out_addr 0..575 in order, each out_data=0x19;
- done high for one cycle, 576*27=15552 cycles after the edge that sampled start.
REQ-023 Image all 0x01, kernel all 0xFF. Required: out_data=0x00 with RELU_EN; out_data=0xE7 (-25) without.
REQ-024 Image all 0xFF, kernel all 0x7F. Required: every out_data=0x7F (saturation). Image all 0xFF, kernel all 0x80 without RELU_EN. Required: 0x80.
REQ-025 Ramp image img[r][c]=r+c, kernel with 0x01 at index 0 only. Required: out[orow][ocol]=orow+ocol, and the first FETCH issues img_addr 0,1,2,3,4,28,29,...
REQ-026 Assert rst for 1 cycle 1000 cycles into a pass. Required:
- all outputs 0 immediately;
- no out_we or done afterwards;
- a new start runs a full 576-write pass.
REQ-027 start held high through the entire pass. Required: exactly one pass with one done; a second pass begins only from the first IDLE cycle after DONE.
